mem_arbiter: RTL and testbench

- Shares the single physical-memory (L2/pmem) line port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined LC-3b core.
- Sits between the two L1 caches and pmem.
- Serialises line transactions with a registered grant FSM.
- Data side has default priority; a bounded streak counter prevents instruction-fetch starvation.

---
 rtl/mem_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single pmem line port between the I-cache miss path
// and the D-cache miss/writeback path.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_pmem_*                  I-cache line read channel (read, address, rdata, resp)
//   d_pmem_*                  D-cache line read/write channel (read, write, address,
//                             wdata, rdata, resp)
//   pmem_*                    physical memory line port (read, write, address, wdata,
//                             rdata, resp)
//   grant_i, grant_d          which side currently owns pmem
//
// The data side wins ties by default. d_streak counts D grants since the last
// I grant. Once it reaches MAX_D_STREAK, a pending I request takes the next
// grant so instruction fetch cannot starve.
module mem_arbiter #(
    parameter int LINE_WIDTH   = 128,
    parameter int ADDR_WIDTH   = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp,
    output logic                  grant_i,
    output logic                  grant_d
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} state_t;

    state_t          state;
    logic [SW-1:0]   d_streak;
    logic            gi_q, gd_q;
    logic            i_req, d_req, streak_full;

    assign i_req       = i_pmem_read;
    assign d_req       = d_pmem_read | d_pmem_write;
    assign streak_full = (d_streak >= SW'(MAX_D_STREAK));

    // Single registered FSM. The grant flags are registered alongside the state,
    // so each flag is exactly a decode of GRANT_I or GRANT_D.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            d_streak <= '0;
            gi_q     <= 1'b0;
            gd_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req && !(i_req && streak_full)) begin
                        state <= GRANT_D;
                        gd_q  <= 1'b1;
                        if (!streak_full)
                            d_streak <= d_streak + 1'b1;
                    end else if (i_req) begin
                        state    <= GRANT_I;
                        gi_q     <= 1'b1;
                        d_streak <= '0;
                    end
                end
                GRANT_I: begin
                    if (pmem_resp) begin
                        state <= RELEASE;
                        gi_q  <= 1'b0;
                    end
                end
                GRANT_D: begin
                    if (pmem_resp) begin
                        state <= RELEASE;
                        gd_q  <= 1'b0;
                    end
                end
                // RELEASE gives the finished requester one cycle to drop its
                // request, so a stale request is never granted a second time.
                default: state <= IDLE;
            endcase
        end
    end

    // Gating with rst forces every output low while reset is held. This also
    // covers the cycle in which reset is first seen, before the flops clear.
    assign grant_i = gi_q & ~rst;
    assign grant_d = gd_q & ~rst;

    // The read data goes to both sides all the time. Each side uses it only
    // while its own resp is high.
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        if (grant_i) begin
            pmem_read    = 1'b1;
            pmem_address = i_pmem_address;
            i_pmem_resp  = pmem_resp;
        end else if (grant_d) begin
            pmem_read    = d_pmem_read;
            pmem_write   = d_pmem_write;
            pmem_address = d_pmem_address;
            pmem_wdata   = d_pmem_wdata;
            d_pmem_resp  = pmem_resp;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: random I/D requesters, a behavioural pmem,
// a scoreboard for returned lines and an arbitration-rule monitor.
module tb_mem_arbiter;

    localparam int LW  = 128;
    localparam int AW  = 16;
    localparam int MAX = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_pmem_read = 1'b0;
    logic [AW-1:0] i_pmem_address = '0;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read = 1'b0;
    logic          d_pmem_write = 1'b0;
    logic [AW-1:0] d_pmem_address = '0;
    logic [LW-1:0] d_pmem_wdata = '0;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata = '0;
    logic          pmem_resp;
    logic          grant_i, grant_d;

    logic          pm_resp = 1'b0;
    logic          force_resp = 1'b0;
    logic          pm_hold = 1'b0;
    int            pm_fix = 5;
    assign pmem_resp = pm_resp | force_resp;

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .MAX_D_STREAK(MAX)) dut (
        .clk(clk), .rst(rst),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .grant_i(grant_i), .grant_d(grant_d)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [LW-1:0] line_init(input logic [AW-1:0] a);
        return {a, 16'hA5C3, ~a, a ^ 16'h1234, {4{a ^ 16'h5A5A}}};
    endfunction

    // ---------------- behavioural pmem ----------------
    logic [LW-1:0] pm_mem [logic [AW-1:0]];
    int            pm_cnt = 0;
    int            pm_lat = 5;

    always begin
        @(posedge clk);
        #2;
        pm_resp = 1'b0;
        if (!rst && !pm_hold && (pmem_read || pmem_write)) begin
            if (pm_cnt >= pm_lat) begin
                if (pmem_write)
                    pm_mem[pmem_address] = pmem_wdata;
                if (pmem_read)
                    pmem_rdata = pm_mem.exists(pmem_address) ? pm_mem[pmem_address] : line_init(pmem_address);
                else
                    pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
                pm_resp = 1'b1;
                pm_cnt  = 0;
                pm_lat  = (pm_fix >= 0) ? pm_fix : int'($urandom_range(0, 5));
            end else begin
                pm_cnt++;
            end
        end else begin
            pm_cnt = 0;
        end
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        bit            is_wr;
        logic [LW-1:0] data;
    } exp_t;

    logic [LW-1:0] ref_d [logic [AW-1:0]];
    logic [LW-1:0] iq [$];
    exp_t          dq [$];
    bit            gseq [$];

    task automatic i_txn(input logic [AW-1:0] a);
        bit got = 1'b0;
        iq.push_back(line_init(a));   // the I region is never written
        i_pmem_read    = 1'b1;
        i_pmem_address = a;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = i_pmem_resp;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL i_timeout: no i_pmem_resp for addr %h", a);
        end
        @(posedge clk);
        #1;
        i_pmem_read = 1'b0;
    endtask

    task automatic d_txn(input bit wr, input logic [AW-1:0] a, input logic [LW-1:0] wd);
        exp_t e;
        bit   got = 1'b0;
        e.is_wr = wr;
        e.data  = wr ? wd : (ref_d.exists(a) ? ref_d[a] : line_init(a));
        if (wr)
            ref_d[a] = wd;
        dq.push_back(e);
        d_pmem_read    = !wr;
        d_pmem_write   = wr;
        d_pmem_address = a;
        d_pmem_wdata   = wd;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clk);
            got = d_pmem_resp;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL d_timeout: no d_pmem_resp for addr %h", a);
        end
        @(posedge clk);
        #1;
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
    endtask

    // ---------------- monitor ----------------
    bit prev_gi = 0, prev_gd = 0, prev2_g = 0, prev_rst = 1;
    bit prev_ireq = 0, prev_dreq = 0;
    int d_since_i = 0;

    always @(negedge clk) begin
        bit gi, gd, exp_i;
        gi = grant_i;
        gd = grant_d;
        check("rdata_i", i_pmem_rdata, pmem_rdata);
        check("rdata_d", d_pmem_rdata, pmem_rdata);
        check("grant_excl", LW'(gi & gd), LW'(0));
        check("d_rw_exclusive", LW'(d_pmem_read & d_pmem_write), LW'(0));
        if (rst || (!gi && !gd)) begin
            check("nogrant_ctl", LW'({gi, gd, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}), LW'(0));
            check("nogrant_addr", LW'(pmem_address), LW'(0));
            check("nogrant_wdata", pmem_wdata, LW'(0));
        end else if (gi) begin
            check("gi_rw", LW'({pmem_read, pmem_write}), LW'(2'b10));
            check("gi_addr", LW'(pmem_address), LW'(i_pmem_address));
            check("gi_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'({pmem_resp, 1'b0}));
            if (prev_gi && !i_pmem_read) begin
                checks++; errors++;
                $display("FAIL i_req_dropped: I request fell while granted at %0t", $time);
            end
        end else begin
            check("gd_rw", LW'({pmem_read, pmem_write}), LW'({d_pmem_read, d_pmem_write}));
            check("gd_addr", LW'(pmem_address), LW'(d_pmem_address));
            check("gd_wdata", pmem_wdata, d_pmem_wdata);
            check("gd_resp", LW'({i_pmem_resp, d_pmem_resp}), LW'({1'b0, pmem_resp}));
            if (prev_gd && !(d_pmem_read || d_pmem_write)) begin
                checks++; errors++;
                $display("FAIL d_req_dropped: D request fell while granted at %0t", $time);
            end
        end

        // A new grant must follow the arbitration rule, applied to the requests
        // seen in the IDLE cycle before it.
        if (!rst && (gi || gd) && !prev_gi && !prev_gd) begin
            exp_i = (prev_ireq && prev_dreq) ? (d_since_i >= MAX) : prev_ireq;
            check("grant_had_req", LW'(prev_ireq | prev_dreq), LW'(1));
            check("winner_is_i", LW'(gi), LW'(exp_i));
            gseq.push_back(gi);
            if (gi) d_since_i = 0;
            else    d_since_i++;
        end
        // Any cycle with no grant that follows another cycle with no grant is IDLE.
        // A request present in IDLE must be granted in the next cycle.
        if (!rst && !prev_rst && !prev_gi && !prev_gd && !prev2_g && (prev_ireq || prev_dreq))
            check("arb_latency", LW'(gi | gd), LW'(1));
        if (rst)
            d_since_i = 0;

        if (i_pmem_resp) begin
            if (iq.size() == 0) begin
                checks++; errors++;
                $display("FAIL i_unexpected_resp: got resp with nothing outstanding at %0t", $time);
            end else begin
                check("i_line", i_pmem_rdata, iq.pop_front());
            end
        end
        if (d_pmem_resp) begin
            if (dq.size() == 0) begin
                checks++; errors++;
                $display("FAIL d_unexpected_resp: got resp with nothing outstanding at %0t", $time);
            end else begin
                exp_t e;
                e = dq.pop_front();
                if (!e.is_wr)
                    check("d_line", d_pmem_rdata, e.data);
            end
        end

        prev2_g   = prev_gi | prev_gd;
        prev_gi   = gi;
        prev_gd   = gd;
        prev_rst  = rst;
        prev_ireq = i_pmem_read;
        prev_dreq = d_pmem_read | d_pmem_write;
    end

    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] seq;
        bit         got;

        // reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", LW'({grant_i, grant_d, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp}), LW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // pmem_resp pulse while IDLE with no requests
        repeat (2) @(posedge clk);
        #1;
        force_resp = 1'b1;
        @(negedge clk);
        check("idle_pulse_resp", LW'({i_pmem_resp, d_pmem_resp, grant_i, grant_d}), LW'(0));
        @(posedge clk);
        #1;
        force_resp = 1'b0;
        @(negedge clk);
        check("idle_pulse_nogrant", LW'({grant_i, grant_d}), LW'(0));
        @(posedge clk);
        #1;

        // lone I read, lone D write, then a D read of the same line
        pm_fix = 5;
        pm_lat = 5;
        i_txn(16'h1230);
        repeat (2) begin @(posedge clk); #1; end
        d_txn(1'b1, 16'h4000, 128'hDEAD0123456789ABCDEF0011223BEEF);
        repeat (2) begin @(posedge clk); #1; end
        d_txn(1'b0, 16'h4000, '0);
        repeat (2) begin @(posedge clk); #1; end

        // reset in the middle of a D grant while pmem holds resp low
        pm_hold        = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 16'h4010;
        d_pmem_wdata   = {4{32'hCAFEF00D}};
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            got = grant_d;
        end
        check("pre_reset_grant_d", LW'(got), LW'(1));
        @(posedge clk);
        #1;
        rst          = 1'b1;
        d_pmem_write = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("after_reset_idle", LW'({grant_i, grant_d, pmem_read, pmem_write}), LW'(0));
        @(posedge clk);
        #1;
        force_resp = 1'b1;
        @(negedge clk);
        check("late_resp_dropped", LW'({i_pmem_resp, d_pmem_resp}), LW'(0));
        @(posedge clk);
        #1;
        force_resp = 1'b0;
        pm_hold    = 1'b0;
        @(negedge clk);
        check("late_resp_nogrant", LW'({grant_i, grant_d}), LW'(0));
        @(posedge clk);
        #1;

        // Both sides request together from IDLE with a clear streak. D is held
        // continuously, so the grants must come out D,D,D,D,I,D.
        pm_fix = 2;
        gseq.delete();
        fork
            for (int n = 0; n < 7; n++)
                d_txn(n[0], 16'h4020 + 16'(n * 16), {4{$urandom}});
            i_txn(16'h1400);
        join
        seq = '0;
        if (gseq.size() < 6) begin
            checks++; errors++;
            $display("FAIL streak_count: got %0d grants expected at least 6", gseq.size());
        end else begin
            for (int n = 0; n < 6; n++)
                seq = {seq[4:0], gseq[n]};
            check("streak_seq", LW'(seq), LW'(6'b000010));
        end
        repeat (2) begin @(posedge clk); #1; end

        // random traffic from both sides
        pm_fix = -1;
        fork
            for (int n = 0; n < 40; n++) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                i_txn({4'h1, 8'($urandom), 4'h0});
            end
            for (int n = 0; n < 60; n++) begin
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                d_txn(1'($urandom), {8'h40, 4'($urandom), 4'h0}, {$urandom, $urandom, $urandom, $urandom});
            end
        join

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("i_queue_empty", LW'(iq.size()), LW'(0));
        check("d_queue_empty", LW'(dq.size()), LW'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
